bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that owns the select side of the shared tristate data bus. It decides which of NUM_INPUT sources may drive the bus, and drives the bus mux select (`sel_out` → `bus_tristate.sel_in`) plus a one-hot grant back to the sources. It enforces a one-cycle bus turnaround between owners and a maximum hold time per grant.

## Interface
Parameters:
- NUM_INPUT, 8, number of requesting sources; must equal the bus mux's NUM_INPUT.
- SEL_BIT, 3, width of the select index; 2^SEL_BIT ≥ NUM_INPUT.
- MAX_HOLD, 16, maximum cycles one grant may last; 1 ≤ MAX_HOLD < 2^HOLD_BIT.
- HOLD_BIT, 5, width of the hold counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_in  in  NUM_INPUT  per-source bus request, level.
- release_in  in  NUM_INPUT  per-source end-of-transfer strobe. Only the bit of the current owner is honoured.
- grant_out  out  NUM_INPUT  one-hot current owner; all zero when the bus is idle.
- sel_out  out  SEL_BIT  binary index of the last granted source; feeds the bus mux select.
- bus_valid_out  out  1  high while a grant is active; the bus data is valid only then.
- timeout_out  out  1  one-cycle pulse when a grant was ended by the hold limit.

## Operation
- Registered state: FSM state, `ptr` (round-robin start, SEL_BIT wide), `owner` index, and `hold_cnt` (HOLD_BIT wide).
- FSM states are IDLE, GRANT and TURN. Reset forces IDLE.
- Arbitration picks the first set bit of `req_in`, scanning upward from `ptr` with wrap at NUM_INPUT-1 → 0. Arbitration is evaluated only in IDLE and TURN.
- IDLE:
  - If any `req_in` is set, go to GRANT. Load `owner` and `sel_out` with the picked index, set `grant_out` one-hot, set `bus_valid_out` = 1, clear `hold_cnt`.
  - Otherwise stay in IDLE.
- GRANT:
  - `hold_cnt` increments every cycle.
  - End the grant when any of these holds: `release_in[owner]`, `!req_in[owner]`, or `hold_cnt == MAX_HOLD-1`.
  - On end: go to TURN, clear `grant_out` and `bus_valid_out`, set `ptr` = `owner`+1 (wrap to 0 past NUM_INPUT-1).
  - `timeout_out` = 1 for the TURN cycle only if the hold limit was the sole cause. A `release_in` or dropped request in the same cycle suppresses the timeout.
- TURN:
  - The bus is undriven for exactly one cycle.
  - Arbitrate with the updated `ptr`. If any request is set, go to GRANT (same actions as from IDLE); otherwise go to IDLE.
- `sel_out` changes only when a grant is issued and holds its value while idle or turning around.
- `release_in` and `req_in` changes of non-owners never affect the current grant.
- After a timeout, a source whose request is still asserted re-competes normally. If it is the only requester, it is re-granted after the TURN cycle.

## Timing
- Reset values: `grant_out` = 0, `sel_out` = 0, `bus_valid_out` = 0, `timeout_out` = 0, `ptr` = 0, `hold_cnt` = 0, state IDLE. Reset taken mid-grant drops the grant on the next edge.
- Request to grant latency: 1 clock. A request sampled at edge k in IDLE gives `grant_out` valid after edge k.
- Release to grant drop: 1 clock. A release sampled at edge t clears `grant_out` after edge t.
- Owner-to-owner gap: exactly one cycle with `bus_valid_out` = 0. The next grant appears after edge t+1.
- Maximum grant length: MAX_HOLD cycles. With MAX_HOLD = 1 every grant lasts exactly one cycle.
- `grant_out`, `sel_out` and `bus_valid_out` all change on the same edge; there is no combinational path from inputs to outputs.

## Structure
- Package `bus_pkg` holds:
  - FSM state encodings (IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2);
  - the shared NUM_INPUT/SEL_BIT/DATA_WIDTH defaults used by `bus_tristate` and `bus_arbiter`.
- One sub-module, `rr_pick`, is a combinational rotating priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: `any`, `idx`.
  - It is instantiated once and shared by the IDLE and TURN paths.

## Test plan
- Reset then single request: `rst` = 1 for 2 cycles, then `req_in` = 8'b0000_1000. Expect grant_out = 8'b0000_1000, sel_out = 3, bus_valid_out = 1 one cycle after `req_in` is sampled. All outputs are 0 during reset.
- Round-robin with wrap: `req_in` = 8'b0000_0110 held, each owner pulses its `release_in` after 2 cycles. Expect owners 1, 2, 1, 2 in that order, with exactly one `bus_valid_out` = 0 cycle between grants.
- Timeout (MAX_HOLD = 16): source 3 holds `req_in` with no release. Expect `grant_out[3]` high for exactly 16 cycles, then a one-cycle TURN with `timeout_out` = 1, then re-grant to 3 (sel_out = 3).
- Release on the last hold cycle: `release_in[owner]` asserted when `hold_cnt` = 15. Expect the grant to end normally and `timeout_out` to stay 0.
- Non-owner noise: owner 5 granted, `release_in` = 8'b0000_0011 pulsed and `req_in[0]` toggled. Expect the grant to remain 8'b0010_0000 with sel_out = 5.
- Reset mid-grant: `rst` during an active grant to 7. Expect the next cycle grant_out = 0, sel_out = 0, and the first request afterwards to be arbitrated from ptr = 0 (req 8'b1000_0001 → grant 0).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants for the tristate bus slice: default sizing and
// arbiter FSM state encodings.
package bus_pkg;

    localparam int DEF_NUM_INPUT  = 8;
    localparam int DEF_SEL_BIT    = 3;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared bus select, with a one-cycle
// turnaround between owners and a hold-time limit per grant.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_INPUT = DEF_NUM_INPUT,
    parameter int SEL_BIT   = DEF_SEL_BIT,
    parameter int MAX_HOLD  = 16,
    parameter int HOLD_BIT  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_INPUT-1:0] req_in,
    input  logic [NUM_INPUT-1:0] release_in,
    output logic [NUM_INPUT-1:0] grant_out,
    output logic [SEL_BIT-1:0]   sel_out,
    output logic                 bus_valid_out,
    output logic                 timeout_out
);

    logic [1:0]          state;
    logic [SEL_BIT-1:0]  ptr;
    logic [SEL_BIT-1:0]  owner;
    logic [HOLD_BIT-1:0] hold_cnt;

    logic               pick_any;
    logic [SEL_BIT-1:0] pick_idx;

    logic               owner_req;
    logic               owner_rel;
    logic               at_limit;
    logic               end_grant;
    logic [SEL_BIT-1:0] nxt_ptr;

    rr_pick #(
        .N (NUM_INPUT),
        .W (SEL_BIT)
    ) u_pick (
        .req (req_in),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_req = req_in[owner];
    assign owner_rel = release_in[owner];
    assign at_limit  = (hold_cnt == HOLD_BIT'(MAX_HOLD - 1));
    assign end_grant = owner_rel || !owner_req || at_limit;
    assign nxt_ptr   = (owner == SEL_BIT'(NUM_INPUT - 1))
                     ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            owner         <= '0;
            hold_cnt      <= '0;
            grant_out     <= '0;
            sel_out       <= '0;
            bus_valid_out <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            timeout_out <= 1'b0;
            unique case (state)
                ST_GRANT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (end_grant) begin
                        state         <= ST_TURN;
                        grant_out     <= '0;
                        bus_valid_out <= 1'b0;
                        ptr           <= nxt_ptr;
                        // only a pure hold-limit expiry is a timeout
                        timeout_out   <= at_limit && !owner_rel && owner_req;
                    end
                end
                default: begin
                    if (pick_any) begin
                        state         <= ST_GRANT;
                        owner         <= pick_idx;
                        sel_out       <= pick_idx;
                        grant_out     <= NUM_INPUT'(1) << pick_idx;
                        bus_valid_out <= 1'b1;
                        hold_cnt      <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a
// cycle-level model built from the arbitration rules.
module tb_bus_arbiter;

    localparam int N    = 8;
    localparam int HOLD = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_in;
    logic [N-1:0] release_in;
    logic [N-1:0] grant_out;
    logic [2:0]   sel_out;
    logic         bus_valid_out;
    logic         timeout_out;

    int checks = 0;
    int errors = 0;

    // model state
    bit m_busy;
    int m_own;
    int m_age;
    int m_rr;
    int m_sel;
    bit m_to;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_INPUT (N),
        .SEL_BIT   (3),
        .MAX_HOLD  (HOLD),
        .HOLD_BIT  (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_in        (req_in),
        .release_in    (release_in),
        .grant_out     (grant_out),
        .sel_out       (sel_out),
        .bus_valid_out (bus_valid_out),
        .timeout_out   (timeout_out)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] q, input int from);
        for (int i = 0; i < N; i++)
            if (q[(from + i) % N]) return (from + i) % N;
        return -1;
    endfunction

    // one rising edge: an owner may hold the bus for at most HOLD
    // cycles; after any grant ends the bus sits idle for a cycle
    task automatic model_step(input logic r, input logic [N-1:0] q,
                              input logic [N-1:0] rel);
        int p;
        if (r) begin
            m_busy = 0; m_age = 0; m_rr = 0; m_sel = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (m_busy) begin
            if (rel[m_own] || !q[m_own] || m_age == HOLD) begin
                m_to   = (m_age == HOLD) && !rel[m_own] && q[m_own];
                m_busy = 0;
                m_rr   = (m_own + 1) % N;
            end else begin
                m_age++;
            end
        end else begin
            p = pick(q, m_rr);
            if (p >= 0) begin
                m_busy = 1; m_own = p; m_sel = p; m_age = 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] q,
                       input logic [N-1:0] rel);
        logic [N-1:0] eg;
        rst = r; req_in = q; release_in = rel;
        @(posedge clk);
        model_step(r, q, rel);
        #1;
        eg = m_busy ? (N'(1) << m_own) : '0;
        check("grant", grant_out, eg);
        check("sel", sel_out, m_sel);
        check("valid", bus_valid_out, m_busy);
        check("timeout", timeout_out, m_to);
    endtask

    function automatic logic [N-1:0] own_bit();
        return m_busy ? (N'(1) << m_own) : '0;
    endfunction

    initial begin
        int cnt;
        logic [N-1:0] q;
        logic [N-1:0] rel;

        m_busy = 0; m_own = 0; m_age = 0; m_rr = 0; m_sel = 0; m_to = 0;

        // reset then single request
        cyc(1, '0, '0);
        cyc(1, '0, '0);
        check("rst_grant", grant_out, 0);
        check("rst_valid", bus_valid_out, 0);
        cyc(0, 8'b0000_1000, '0);
        check("t1_grant", grant_out, 8'b0000_1000);
        check("t1_sel", sel_out, 3);
        check("t1_valid", bus_valid_out, 1);

        // round robin between 1 and 2, release after 2 cycles
        cyc(1, '0, '0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 8'b0000_0110, '0);
            check("rr_owner", sel_out, (k % 2 == 0) ? 1 : 2);
            cyc(0, 8'b0000_0110, '0);
            cyc(0, 8'b0000_0110, own_bit());
            check("rr_gap", bus_valid_out, 0);
        end

        // timeout with source 3 holding forever
        cyc(1, '0, '0);
        cyc(0, 8'b0000_1000, '0);
        cnt = 0;
        for (int k = 0; k < 40 && grant_out[3]; k++) begin
            cnt++;
            cyc(0, 8'b0000_1000, '0);
        end
        check("to_len", cnt, HOLD);
        check("to_pulse", timeout_out, 1);
        cyc(0, 8'b0000_1000, '0);
        check("to_regrant", grant_out, 8'b0000_1000);
        check("to_resel", sel_out, 3);

        // release on the last allowed hold cycle
        cyc(1, '0, '0);
        cyc(0, 8'b0000_1000, '0);
        for (int k = 0; k < HOLD - 1; k++) cyc(0, 8'b0000_1000, '0);
        cyc(0, 8'b0000_1000, 8'b0000_1000);
        check("last_rel_drop", bus_valid_out, 0);
        check("last_rel_to", timeout_out, 0);

        // non-owner noise
        cyc(1, '0, '0);
        cyc(0, 8'b0010_0000, '0);
        cyc(0, 8'b0010_0001, 8'b0000_0011);
        cyc(0, 8'b0010_0000, '0);
        cyc(0, 8'b0010_0001, 8'b0000_0011);
        check("noise_grant", grant_out, 8'b0010_0000);
        check("noise_sel", sel_out, 5);

        // reset mid-grant
        cyc(1, '0, '0);
        cyc(0, 8'b1000_0000, '0);
        cyc(0, 8'b1000_0000, '0);
        cyc(1, 8'b1000_0000, '0);
        check("mid_rst_grant", grant_out, 0);
        check("mid_rst_sel", sel_out, 0);
        cyc(0, 8'b1000_0001, '0);
        check("mid_rst_pick", grant_out, 8'b0000_0001);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            q = ($urandom_range(0, 3) == 0) ? N'($urandom) : (req_in | N'($urandom) & N'($urandom) & N'($urandom));
            rel = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            cyc($urandom_range(0, 199) == 0, q, rel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
